// File: rtl/des_key_schedule_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : des_key_schedule_ctrl
//  Brief    : Sequences a DES subkey generator through keyid 1..16 for a
//             latched 64-bit key, stores the 16 returned 48-bit subkeys in a
//             local bank and serves them to the round engine by round number
//             in encrypt or decrypt order.
//  Revision : 1.0 - initial release
// ============================================================================
module des_key_schedule_ctrl #(
    parameter int GEN_LAT = 8,   // pulse-to-sample latency of the generator (>=6)
    parameter int GEN_GAP = 1    // idle cycles after each sample (>=1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [63:0] key_in,
    input  logic        abort,
    output logic        gen_start,
    output logic [5:0]  gen_keyid,
    output logic [63:0] gen_key,
    input  logic [47:0] gen_branchkey,
    output logic        busy,
    output logic        sched_done,
    output logic        bank_valid,
    input  logic        rd_en,
    input  logic [3:0]  rd_round,
    input  logic        rd_decrypt,
    output logic [47:0] rd_subkey,
    output logic        rd_valid
);

    localparam int                 c_CNT_W     = $clog2(GEN_LAT + GEN_GAP + 1);
    localparam logic [c_CNT_W-1:0] c_PRIME_END = c_CNT_W'(GEN_LAT + GEN_GAP);
    localparam logic [c_CNT_W-1:0] c_LAT_END   = c_CNT_W'(GEN_LAT);
    localparam logic [c_CNT_W-1:0] c_GAP_END   = c_CNT_W'(GEN_GAP);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [3:0]         r_k;
    logic [3:0]         w_k_nxt;
    logic               w_accept;
    logic               w_capture;
    logic               w_done;
    logic               w_gen_start;
    logic [63:0]        r_gen_key;
    logic               r_bank_valid;
    logic [47:0]        r_bank [16];
    logic [3:0]         w_rd_addr;
    logic               w_rd_hit;
    logic               r_rd_valid;
    logic [47:0]        r_rd_subkey;

    // State, phase counter and subkey index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_k     <= w_k_nxt;
        end
    end

    // Next-state logic; PRIME's discarded result means its pulse is the
    // first of 17, the remaining 16 fill the bank in keyid order
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_k_nxt     = r_k;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_done      = 1'b0;
        w_gen_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (key_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_PRIME;
                    w_cnt_nxt   = '0;
                    w_k_nxt     = '0;
                end
            end
            ST_PRIME: begin
                w_gen_start = (r_cnt == '0);
                if (r_cnt == c_PRIME_END) begin
                    w_state_nxt = ST_ISSUE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            ST_ISSUE: begin
                w_gen_start = 1'b1;
                w_state_nxt = ST_WAIT;
                w_cnt_nxt   = c_CNT_ONE;
            end
            ST_WAIT: begin
                if (r_cnt == c_LAT_END) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = c_CNT_ONE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            ST_GAP: begin
                if (r_cnt == c_GAP_END) begin
                    w_cnt_nxt = '0;
                    if (r_k == 4'd15) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_k_nxt     = r_k + 4'd1;
                        w_state_nxt = ST_ISSUE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Abort wins over everything, including a completion in the same cycle
        if (abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_capture   = 1'b0;
            w_done      = 1'b0;
        end
    end

    // Key latch and bank-valid flag; the flag only rises on a full schedule
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gen_key    <= '0;
            r_bank_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_gen_key <= key_in;
            end
            if (w_accept) begin
                r_bank_valid <= 1'b0;
            end else if (w_done) begin
                r_bank_valid <= 1'b1;
            end
        end
    end

    // Subkey bank; contents are meaningless until bank_valid, so no reset
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_bank[r_k] <= gen_branchkey;
        end
    end

    assign w_rd_addr = rd_decrypt ? (4'd15 - rd_round) : rd_round;
    assign w_rd_hit  = rd_en & r_bank_valid;

    // Registered read port, zero data whenever the read is not valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid  <= 1'b0;
            r_rd_subkey <= '0;
        end else begin
            r_rd_valid  <= w_rd_hit;
            r_rd_subkey <= w_rd_hit ? r_bank[w_rd_addr] : 48'd0;
        end
    end

    assign key_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign gen_start  = w_gen_start;
    assign gen_keyid  = {2'b00, r_k} + 6'd1;
    assign gen_key    = r_gen_key;
    assign sched_done = w_done;
    assign bank_valid = r_bank_valid;
    assign rd_valid   = r_rd_valid;
    assign rd_subkey  = r_rd_subkey;

endmodule
`default_nettype wire

// File: tb/tb_des_key_schedule_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_des_key_schedule_ctrl
//  Brief    : Self-checking bench for des_key_schedule_ctrl with a behavioural
//             DES subkey generator and a read scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_des_key_schedule_ctrl;

    localparam int          GEN_LAT = 8;
    localparam int          GEN_GAP = 1;
    localparam int          EXP_LAT = 17 * (1 + GEN_LAT + GEN_GAP) + 1;
    localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B   = 64'h0E329232EA6D0D73;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic        key_ready;
    logic [63:0] key_in;
    logic        abort;
    logic        gen_start;
    logic [5:0]  gen_keyid;
    logic [63:0] gen_key;
    logic [47:0] gen_branchkey;
    logic        busy;
    logic        sched_done;
    logic        bank_valid;
    logic        rd_en;
    logic [3:0]  rd_round;
    logic        rd_decrypt;
    logic [47:0] rd_subkey;
    logic        rd_valid;

    des_key_schedule_ctrl #(
        .GEN_LAT(GEN_LAT),
        .GEN_GAP(GEN_GAP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_in       (key_in),
        .abort        (abort),
        .gen_start    (gen_start),
        .gen_keyid    (gen_keyid),
        .gen_key      (gen_key),
        .gen_branchkey(gen_branchkey),
        .busy         (busy),
        .sched_done   (sched_done),
        .bank_valid   (bank_valid),
        .rd_en        (rd_en),
        .rd_round     (rd_round),
        .rd_decrypt   (rd_decrypt),
        .rd_subkey    (rd_subkey),
        .rd_valid     (rd_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- DES key schedule reference ----------------
    int pc1 [56] = '{57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
                     10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
                     63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
    int pc2 [48] = '{14,17,11,24, 1, 5, 3,28,15, 6,21,10,
                     23,19,12, 4,26, 8,16, 7,27,20,13, 2,
                     41,52,31,37,47,55,30,40,51,45,33,48,
                     44,49,39,56,34,53,46,42,50,36,29,32};
    int shifts [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    function automatic logic [47:0] des_subkey(input logic [63:0] key, input int id);
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        logic [47:0] k;
        if (id < 1 || id > 16) return 48'hEEEE_EEEE_EEEE;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-pc1[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < id; r++) begin
            for (int s = 0; s < shifts[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) k[47-i] = cd[56-pc2[i]];
        return k;
    endfunction

    // ---------------- generator model ----------------
    // Needs one request with a new key before it returns real subkeys; the
    // result is only present in the single cycle GEN_LAT after the pulse.
    int          cyc       = 0;
    int          pulse_cyc = -100;
    logic [47:0] g_val     = '0;
    logic [63:0] g_pkey    = '0;
    logic        g_primed  = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (gen_start) begin
            pulse_cyc <= cyc;
            if (g_primed && g_pkey == gen_key) begin
                g_val <= des_subkey(gen_key, int'(gen_keyid));
            end else begin
                g_val    <= 48'h5A5A_0BAD_F00D;
                g_primed <= 1'b1;
                g_pkey   <= gen_key;
            end
        end
    end

    assign gen_branchkey = (cyc == pulse_cyc + GEN_LAT) ? g_val : {16'hBAD0, cyc};

    // ---------------- pulse / completion monitor ----------------
    int   keyids[$];
    int   pulses_adj = 0;
    int   done_cnt   = 0;
    logic prev_gs    = 1'b0;

    always @(posedge clk) begin
        if (gen_start) begin
            keyids.push_back(int'(gen_keyid));
            if (prev_gs) pulses_adj <= pulses_adj + 1;
        end
        prev_gs <= gen_start;
        if (sched_done) done_cnt <= done_cnt + 1;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- read scoreboard ----------------
    logic        sb_v[$];
    logic [47:0] sb_d[$];
    string       sb_n[$];

    task automatic issue_read(input logic [3:0] r, input logic d, input logic ev,
                              input logic [47:0] ed, input string nm);
        rd_en      = 1'b1;
        rd_round   = r;
        rd_decrypt = d;
        sb_v.push_back(ev);
        sb_d.push_back(ed);
        sb_n.push_back(nm);
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        logic pend;
        logic ev;
        logic [47:0] ed;
        string nm;
        forever begin
            @(posedge clk);
            pend = rd_en;
            #1;
            if (pend) begin
                if (sb_v.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got a read with no expectation queued, required one");
                end else begin
                    ev = sb_v.pop_front();
                    ed = sb_d.pop_front();
                    nm = sb_n.pop_front();
                    check({nm, "_valid"}, 64'(rd_valid), 64'(ev));
                    check({nm, "_data"}, 64'(rd_subkey), 64'(ed));
                end
            end
        end
    end

    task automatic check_reset_vals(input string p);
        check({p, "_key_ready"}, 64'(key_ready), 64'd1);
        check({p, "_busy"}, 64'(busy), 64'd0);
        check({p, "_gen_start"}, 64'(gen_start), 64'd0);
        check({p, "_gen_keyid"}, 64'(gen_keyid), 64'd1);
        check({p, "_gen_key"}, gen_key, 64'd0);
        check({p, "_sched_done"}, 64'(sched_done), 64'd0);
        check({p, "_bank_valid"}, 64'(bank_valid), 64'd0);
        check({p, "_rd_valid"}, 64'(rd_valid), 64'd0);
        check({p, "_rd_subkey"}, 64'(rd_subkey), 64'd0);
    endtask

    task automatic start_key(input logic [63:0] key);
        int n = 0;
        while (!key_ready && n < 50) begin tick(); n++; end
        check("key_ready_before_start", 64'(key_ready), 64'd1);
        key_valid = 1'b1;
        key_in    = key;
        tick();
        key_valid = 1'b0;
    endtask

    // Latency counts cycles inclusively from the accept cycle up to and
    // including the cycle in which sched_done is high.
    task automatic run_key(input logic [63:0] key, input bit rd_at_done, input bit intrude,
                           input logic [63:0] ikey, output int lat);
        int n;
        bit kr;
        start_key(key);
        if (intrude) begin
            key_valid = 1'b1;
            key_in    = ikey;
        end
        kr = 1'b0;
        n  = 1;
        while (!sched_done && n < 400) begin
            kr |= key_ready;
            tick();
            n++;
        end
        kr |= key_ready;
        key_valid = 1'b0;
        check("sched_done_seen", 64'(sched_done), 64'd1);
        if (intrude) check("key_ready_while_busy", 64'(kr), 64'd0);
        lat = n + 1;
        if (rd_at_done) issue_read(4'd0, 1'b0, 1'b0, 48'd0, "rd_at_sched_done");
        else tick();
        check("bank_valid_after_done", 64'(bank_valid), 64'd1);
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic wait_pulses(input int nth);
        int n = 0;
        while (keyids.size() < nth && n < 400) begin tick(); n++; end
        check("pulse_wait", 64'(keyids.size() >= nth), 64'd1);
    endtask

    task automatic read_all(input logic [63:0] key, input logic dec, input string tag);
        for (int r = 0; r < 16; r++) begin
            issue_read(4'(r), dec, 1'b1, des_subkey(key, dec ? 16 - r : r + 1),
                       $sformatf("%s_r%0d", tag, r));
        end
    endtask

    typedef struct {
        logic [3:0]  round;
        logic        dec;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs[6];

    // ---------------- test sequence ----------------
    initial begin
        int lat;
        int d0;

        vecs[0] = '{4'd0,  1'b0, 48'h1B02EFFC7072};
        vecs[1] = '{4'd15, 1'b0, 48'hCB3D8B0E17F5};
        vecs[2] = '{4'd0,  1'b1, 48'hCB3D8B0E17F5};
        vecs[3] = '{4'd15, 1'b1, 48'h1B02EFFC7072};
        vecs[4] = '{4'd1,  1'b0, 48'h79AED9DBC9E5};
        vecs[5] = '{4'd14, 1'b1, 48'h79AED9DBC9E5};

        rst_n      = 1'b0;
        key_valid  = 1'b0;
        key_in     = '0;
        abort      = 1'b0;
        rd_en      = 1'b0;
        rd_round   = '0;
        rd_decrypt = 1'b0;
        #2;
        check_reset_vals("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_reset_vals("post_reset");

        // Key A: latency, pulse train, read coinciding with sched_done
        keyids.delete();
        run_key(KEY_A, 1'b1, 1'b0, 64'd0, lat);
        check("latency_a", 64'(lat), 64'(EXP_LAT));
        check("pulse_count", 64'(keyids.size()), 64'd17);
        for (int i = 0; i < keyids.size() && i < 17; i++)
            check($sformatf("keyid_%0d", i), 64'(keyids[i]), 64'(i == 0 ? 1 : i));
        check("pulse_adjacent", 64'(pulses_adj), 64'd0);
        check("gen_key_a", gen_key, KEY_A);

        for (int i = 0; i < 6; i++)
            issue_read(vecs[i].round, vecs[i].dec, 1'b1, vecs[i].exp, $sformatf("vec%0d", i));
        read_all(KEY_A, 1'b0, "a_enc");
        read_all(KEY_A, 1'b1, "a_dec");

        // Second key offered while busy must be ignored
        run_key(KEY_B, 1'b0, 1'b1, KEY_A, lat);
        check("latency_b", 64'(lat), 64'(EXP_LAT));
        check("gen_key_b", gen_key, KEY_B);
        read_all(KEY_B, 1'b0, "b_enc");

        // Abort while idle does nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_bank_valid", 64'(bank_valid), 64'd1);
        check("idle_abort_key_ready", 64'(key_ready), 64'd1);

        // Abort after the fifth capture
        keyids.delete();
        d0 = done_cnt;
        start_key(KEY_A);
        wait_pulses(7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_key_ready", 64'(key_ready), 64'd1);
        check("abort_bank_valid", 64'(bank_valid), 64'd0);
        check("abort_gen_start", 64'(gen_start), 64'd0);
        repeat (GEN_LAT + 2) tick();
        check("abort_no_done", 64'(done_cnt), 64'(d0));
        check("abort_no_pulses", 64'(keyids.size()), 64'd7);
        issue_read(4'd3, 1'b0, 1'b0, 48'd0, "rd_after_abort");
        run_key(KEY_B, 1'b0, 1'b0, 64'd0, lat);
        check("latency_after_abort", 64'(lat), 64'(EXP_LAT));
        read_all(KEY_B, 1'b1, "b_dec");

        // Reset in the middle of a WAIT phase
        keyids.delete();
        start_key(KEY_A);
        wait_pulses(3);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_key(KEY_A, 1'b0, 1'b0, 64'd0, lat);
        check("latency_after_reset", 64'(lat), 64'(EXP_LAT));
        for (int i = 0; i < 4; i++)
            issue_read(vecs[i].round, vecs[i].dec, 1'b1, vecs[i].exp, $sformatf("rst_vec%0d", i));

        tick();
        tick();
        check("sb_empty", 64'(sb_v.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
